// File: rtl/apb4_if.sv
// apb4_if: APB4 bus bundle carrying the bus clock and active-low reset.
interface apb4_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          pclk;
    logic          presetn;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslerr;

    modport master (
        input  pclk, presetn, prdata, pready, pslerr,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        input  pclk, presetn, paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslerr
    );
endinterface

// File: rtl/apb4_ps2_rx.sv
// apb4_ps2_rx: PS/2 device-to-host receiver with filtered inputs, receive FIFO and APB4 register access.
module apb4_ps2_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    apb4_if.slave apb4,
    input  logic  ps2_clk_i,
    input  logic  ps2_dat_i,
    output logic  irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

    logic clk, rst_n;
    assign clk   = apb4.pclk;
    assign rst_n = apb4.presetn;

    // bit 0 = ps2 clock line, bit 1 = ps2 data line
    logic [1:0]         s1_q, s1_d, s2_q, s2_d, f_q, f_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    logic               stb, dat;

    state_e             state_q, state_d;
    logic [2:0]         bidx_q, bidx_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic [WW-1:0]      wdog_q, wdog_d;
    logic               push_q, push_d;
    logic [7:0]         byte_q, byte_d;
    logic               ferr_set, perr_set, ovf_set;

    logic               en_q, en_d, irqen_q, irqen_d, pdrop_q, pdrop_d;
    logic               flush_q, flush_d;
    logic [7:0]         thresh_q, thresh_d;
    logic               ovf_q, ovf_d, perr_q, perr_d, ferr_q, ferr_d;
    logic               irq_q, irq_d;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [8:0]         count_q, count_d;

    logic [1:0]         sel;
    logic               rd_acc, wr_acc, pop, do_push, full, nempty;
    logic [8:0]         thr;
    logic [31:0]        ctrl_rd, stat_rd, data_rd;
    logic               unused_ok;

    assign apb4.pready  = 1'b1;
    assign apb4.pslerr  = 1'b0;
    assign irq_o        = irq_q;
    assign unused_ok    = ^{apb4.pwdata[31:16], apb4.pwdata[7:5], apb4.paddr[1:0]};

    // Synchronise, then require FILTER_LEN consecutive differing samples before the filtered value follows
    always_comb begin
        s1_d = {ps2_dat_i, ps2_clk_i};
        s2_d = s1_q;
        f_d  = f_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != f_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) f_d[i] = s2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
        stb = f_q[0] & ~f_d[0];
        dat = f_q[1];
    end

    always_comb begin
        state_d  = state_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        wdog_d   = '0;
        push_d   = 1'b0;
        byte_d   = shift_q;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        if (!en_q) begin
            state_d = IDLE;
        end else begin
            if (state_q != IDLE) wdog_d = stb ? '0 : wdog_q + WW'(1);
            case (state_q)
                IDLE: begin
                    if (stb && dat) ferr_set = 1'b1;
                    else if (stb) begin
                        state_d = DATA;
                        bidx_d  = 3'd0;
                    end
                end
                DATA: begin
                    if (stb) begin
                        shift_d = {dat, shift_q[7:1]};
                        bidx_d  = bidx_q + 3'd1;
                        state_d = (bidx_q == 3'd7) ? PARITY : DATA;
                    end
                end
                PARITY: begin
                    if (stb) begin
                        par_d   = dat;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (stb) begin
                        state_d = IDLE;
                        if (!dat) ferr_set = 1'b1;
                        else if (^{shift_q, par_q}) push_d = 1'b1;
                        else begin
                            perr_set = 1'b1;
                            push_d   = ~pdrop_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_q != IDLE && !stb && wdog_q == WW'(TIMEOUT_CYC - 1)) begin
                state_d  = IDLE;
                wdog_d   = '0;
                ferr_set = 1'b1;
            end
        end
    end

    // A push meeting a pending flush is dropped silently; a push on a full FIFO only lands if a pop frees a slot
    always_comb begin
        sel     = apb4.paddr[3:2];
        rd_acc  = apb4.psel & apb4.penable & ~apb4.pwrite;
        wr_acc  = apb4.psel & apb4.penable & apb4.pwrite;
        full    = count_q == 9'(FIFO_DEPTH);
        nempty  = count_q != 9'd0;
        pop     = rd_acc & (sel == 2'd2) & nempty & ~flush_q;
        do_push = push_q & (~full | pop) & ~flush_q;
        ovf_set = push_q & full & ~pop & ~flush_q;
        wptr_d  = flush_q ? '0 : wptr_q + AW'(do_push);
        rptr_d  = flush_q ? '0 : rptr_q + AW'(pop);
        count_d = flush_q ? '0 : count_q + {8'd0, do_push} - {8'd0, pop};
    end

    always_comb begin
        en_d     = en_q;
        irqen_d  = irqen_q;
        pdrop_d  = pdrop_q;
        thresh_d = thresh_q;
        flush_d  = 1'b0;
        if (wr_acc && sel == 2'd0) begin
            en_d     = apb4.pwdata[0];
            irqen_d  = apb4.pwdata[1];
            pdrop_d  = apb4.pwdata[2];
            flush_d  = apb4.pwdata[3];
            thresh_d = apb4.pwdata[15:8];
        end
        ovf_d  = (ovf_q  & ~(wr_acc && sel == 2'd1 && apb4.pwdata[2])) | ovf_set;
        perr_d = (perr_q & ~(wr_acc && sel == 2'd1 && apb4.pwdata[3])) | perr_set;
        ferr_d = (ferr_q & ~(wr_acc && sel == 2'd1 && apb4.pwdata[4])) | ferr_set;
        thr    = (thresh_q == 8'd0) ? 9'd1 : {1'b0, thresh_q};
        irq_d  = irqen_q & ((count_q >= thr) | ovf_q | perr_q | ferr_q);
    end

    always_comb begin
        ctrl_rd     = {16'd0, thresh_q, 5'd0, pdrop_q, irqen_q, en_q};
        stat_rd     = {15'd0, count_q, 3'd0, ferr_q, perr_q, ovf_q, full, nempty};
        data_rd     = {24'd0, nempty ? mem_q[rptr_q] : 8'd0};
        apb4.prdata = (sel == 2'd0) ? ctrl_rd :
                      (sel == 2'd1) ? stat_rd :
                      (sel == 2'd2) ? data_rd : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 2'b11;
            s2_q     <= 2'b11;
            f_q      <= 2'b11;
            fcnt_q   <= '0;
            state_q  <= IDLE;
            bidx_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            wdog_q   <= '0;
            push_q   <= 1'b0;
            byte_q   <= '0;
            en_q     <= 1'b0;
            irqen_q  <= 1'b0;
            pdrop_q  <= 1'b0;
            flush_q  <= 1'b0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            irq_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            f_q      <= f_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            bidx_q   <= bidx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            wdog_q   <= wdog_d;
            push_q   <= push_d;
            byte_q   <= byte_d;
            en_q     <= en_d;
            irqen_q  <= irqen_d;
            pdrop_q  <= pdrop_d;
            flush_q  <= flush_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            irq_q    <= irq_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_apb4_ps2_rx.sv
// tb_apb4_ps2_rx: directed PS/2 frames and APB accesses against hand-computed register values.
module tb_apb4_ps2_rx;
    localparam int DEPTH = 4;
    localparam int TOUT  = 200;

    apb4_if bus ();
    logic ps2_clk, ps2_dat, irq;
    int   tests, failed;
    logic [31:0] rd;

    apb4_ps2_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYC(TOUT)) dut (
        .apb4(bus), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat), .irq_o(irq)
    );

    initial bus.pclk = 1'b0;
    always #5 bus.pclk = ~bus.pclk;

    task automatic tick(input int n);
        repeat (n) @(posedge bus.pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
        tick(1);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
        tick(1);
        bus.penable = 1'b1;
        tick(1);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [3:0] a, output logic [31:0] d);
        tick(1);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        tick(1);
        bus.penable = 1'b1;
        #1 d = bus.prdata;
        tick(1);
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        apb_rd(a, v);
        check(tag, v, exp);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    task automatic send(input logic [7:0] b, input logic par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par_ok ? ~^b : ^b);
        ps2_bit(stop);
        ps2_dat = 1'b1;
        tick(10);
    endtask

    initial begin
        tests = 0; failed = 0;
        ps2_clk = 1'b1; ps2_dat = 1'b1;
        bus.presetn = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        tick(3);
        bus.presetn = 1'b1;
        tick(2);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {30'd0, bus.pready, bus.pslerr}, 32'd2);
        rd_chk("rst_ctrl", 4'h0, 32'h0);
        rd_chk("rst_stat", 4'h4, 32'h0);
        rd_chk("rst_data", 4'h8, 32'h0);

        send(8'h1C, 1'b1, 1'b1);
        rd_chk("dis_stat", 4'h4, 32'h0);

        apb_wr(4'h0, 32'h1);
        rd_chk("en_ctrl", 4'h0, 32'h1);
        send(8'h1C, 1'b1, 1'b1);
        rd_chk("1c_stat", 4'h4, 32'h101);
        rd_chk("1c_data", 4'h8, 32'h1C);
        rd_chk("1c_empty", 4'h4, 32'h0);

        apb_wr(4'hC, 32'hFFFF_FFFF);
        rd_chk("rsv_rd", 4'hC, 32'h0);
        rd_chk("rsv_ctrl", 4'h0, 32'h1);

        apb_wr(4'h0, 32'h5);
        send(8'hF0, 1'b0, 1'b1);
        rd_chk("pdrop_stat", 4'h4, 32'h08);
        apb_wr(4'h4, 32'h08);
        rd_chk("perr_w1c", 4'h4, 32'h0);
        apb_wr(4'h0, 32'h1);
        send(8'hF0, 1'b0, 1'b1);
        rd_chk("pkeep_stat", 4'h4, 32'h109);
        rd_chk("pkeep_data", 4'h8, 32'hF0);
        apb_wr(4'h4, 32'h1C);

        send(8'h55, 1'b1, 1'b0);
        rd_chk("stop_ferr", 4'h4, 32'h10);
        apb_wr(4'h4, 32'h1C);

        send(8'h11, 1'b1, 1'b1);
        send(8'h22, 1'b1, 1'b1);
        send(8'h33, 1'b1, 1'b1);
        send(8'h44, 1'b1, 1'b1);
        rd_chk("full_noovf", 4'h4, 32'h403);
        send(8'h55, 1'b1, 1'b1);
        rd_chk("ovf_stat", 4'h4, 32'h407);
        rd_chk("ovf_d0", 4'h8, 32'h11);
        rd_chk("ovf_d1", 4'h8, 32'h22);
        rd_chk("ovf_d2", 4'h8, 32'h33);
        rd_chk("ovf_d3", 4'h8, 32'h44);
        rd_chk("empty_rd", 4'h8, 32'h0);
        rd_chk("ovf_left", 4'h4, 32'h04);
        apb_wr(4'h4, 32'h1C);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_dat = 1'b1;
        tick(100);
        rd_chk("wd_early", 4'h4, 32'h0);
        tick(200);
        rd_chk("wd_ferr", 4'h4, 32'h10);
        apb_wr(4'h4, 32'h1C);
        send(8'h5A, 1'b1, 1'b1);
        rd_chk("wd_next", 4'h8, 32'h5A);

        ps2_clk = 1'b0; tick(1); ps2_clk = 1'b1; tick(20);
        rd_chk("glitch1", 4'h4, 32'h0);
        ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(20);
        rd_chk("glitch3", 4'h4, 32'h0);

        apb_wr(4'h0, 32'h303);
        send(8'h01, 1'b1, 1'b1);
        send(8'h02, 1'b1, 1'b1);
        check("irq_two", {31'd0, irq}, 32'd0);
        send(8'h03, 1'b1, 1'b1);
        check("irq_three", {31'd0, irq}, 32'd1);
        rd_chk("irq_pop", 4'h8, 32'h01);
        tick(2);
        check("irq_fall", {31'd0, irq}, 32'd0);
        rd_chk("irq_d1", 4'h8, 32'h02);
        rd_chk("irq_d2", 4'h8, 32'h03);

        apb_wr(4'h0, 32'h003);
        tick(2);
        check("thr0_empty", {31'd0, irq}, 32'd0);
        send(8'h04, 1'b1, 1'b1);
        check("thr0_one", {31'd0, irq}, 32'd1);
        rd_chk("thr0_data", 4'h8, 32'h04);

        apb_wr(4'h0, 32'h803);
        send(8'h10, 1'b1, 1'b1);
        send(8'h20, 1'b1, 1'b1);
        send(8'h30, 1'b1, 1'b1);
        send(8'h40, 1'b1, 1'b1);
        rd_chk("big_thr_stat", 4'h4, 32'h403);
        check("big_thr_irq", {31'd0, irq}, 32'd0);
        apb_wr(4'h0, 32'h80B);
        rd_chk("flush_stat", 4'h4, 32'h0);
        rd_chk("flush_ctrl", 4'h0, 32'h803);
        rd_chk("flush_data", 4'h8, 32'h0);

        apb_wr(4'h0, 32'h1);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        apb_wr(4'h0, 32'h0);
        tick(300);
        rd_chk("endis_stat", 4'h4, 32'h0);
        apb_wr(4'h0, 32'h1);
        send(8'h3C, 1'b1, 1'b1);
        rd_chk("endis_next", 4'h8, 32'h3C);

        ps2_bit(1'b0); ps2_bit(1'b1);
        bus.presetn = 1'b0;
        tick(2);
        bus.presetn = 1'b1;
        tick(300);
        rd_chk("mrst_stat", 4'h4, 32'h0);
        rd_chk("mrst_ctrl", 4'h0, 32'h0);
        apb_wr(4'h0, 32'h1);
        send(8'h7E, 1'b1, 1'b1);
        rd_chk("mrst_next", 4'h8, 32'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
